// File: rtl/mips_mc_datapath.sv
// Multi-cycle 16-bit-ISA MIPS datapath: one shared memory port with a stall engine,
// hardwired-zero r0, sign-extended immediates and NUM_OUT output ports.
module mips_mc_datapath #(
  parameter int DATA_W  = 16,
  parameter int NUM_OUT = 2,
  parameter int PC_STEP = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IorD,
  input  logic                        MemStart,
  input  logic                        MemWE,
  input  logic                        IRWrite,
  input  logic                        PCWrite,
  input  logic                        PCWriteCond,
  input  logic [1:0]                  PCSrc,
  input  logic                        ALUSrcA,
  input  logic [1:0]                  ALUSrcB,
  input  logic [2:0]                  ALUOp,
  input  logic [1:0]                  RegDst,
  input  logic [1:0]                  MemtoReg,
  input  logic                        RegWrite,
  input  logic                        OutEn,
  input  logic [DATA_W-1:0]           in_port,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_busy,
  output logic                        mem_done,
  output logic [15:0]                 instr,
  output logic                        zero_flag,
  output logic [NUM_OUT*DATA_W-1:0]   out_port,
  output logic [NUM_OUT-1:0]          out_strobe
);
  // Memory handshake: mem_req is a level held from the start edge until the edge
  // that samples mem_ready=1; mem_ready is a one-cycle completion pulse.
  typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_t;

  mem_state_t        state_q, state_d;
  logic              mem_start, mem_complete, irw_q, stall;
  logic [DATA_W-1:0] pc_q, mdr_q, a_q, b_q, alu_out_q;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] rf_q [8];
  logic [2:0]        rs, rt, rd, wa;
  logic [DATA_W-1:0] sext, alu_a, alu_b, alu_y, pc_next, wd, rs_val, rt_val;
  logic              pc_we, rf_we, out_we;

  assign rs       = ir_q[11:9];
  assign rt       = ir_q[8:6];
  assign rd       = ir_q[5:3];
  assign sext     = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
  assign instr    = ir_q;
  assign mem_busy = (state_q == MEM_WAIT);
  assign stall    = mem_busy;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_start    = 1'b0;
    mem_complete = 1'b0;
    case (state_q)
      MEM_IDLE: if (MemStart) begin
        state_d   = MEM_WAIT;
        mem_start = 1'b1;
      end
      MEM_WAIT: if (mem_ready) begin
        state_d      = MEM_IDLE;
        mem_complete = 1'b1;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_done  <= 1'b0;
      irw_q     <= 1'b0;
      mdr_q     <= '0;
      ir_q      <= '0;
    end else begin
      mem_done <= 1'b0;
      if (mem_start) begin
        mem_addr  <= IorD ? alu_out_q : pc_q;
        mem_wdata <= b_q;
        mem_we    <= MemWE;
        irw_q     <= IRWrite;
        mem_req   <= 1'b1;
      end
      if (mem_complete) begin
        mdr_q <= mem_rdata;
        // Only reads may refill IR; a write's returned data is not an instruction.
        if (irw_q && !mem_we) ir_q <= mem_rdata[15:0];
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        mem_done <= 1'b1;
      end
    end
  end

  always_comb begin
    alu_a = ALUSrcA ? a_q : pc_q;
    case (ALUSrcB)
      2'b00:   alu_b = b_q;
      2'b01:   alu_b = DATA_W'(PC_STEP);
      2'b10:   alu_b = sext;
      default: alu_b = {sext[DATA_W-2:0], 1'b0};
    endcase
    case (ALUOp)
      3'b000:  alu_y = alu_a + alu_b;
      3'b001:  alu_y = alu_a - alu_b;
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      3'b101:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      3'b110:  alu_y = alu_a << alu_b[3:0];
      default: alu_y = alu_a >> alu_b[3:0];
    endcase
  end

  assign zero_flag = (alu_y == '0);

  always_comb begin
    case (PCSrc)
      2'b00:   pc_next = alu_y;
      2'b01:   pc_next = alu_out_q;
      2'b10:   pc_next = {pc_q[DATA_W-1:13], ir_q[11:0], 1'b0};
      default: pc_next = a_q;
    endcase
    case (RegDst)
      2'b01:   wa = rd;
      2'b10:   wa = 3'd7;
      default: wa = rt;
    endcase
    case (MemtoReg)
      2'b00:   wd = alu_out_q;
      2'b01:   wd = mdr_q;
      2'b10:   wd = pc_q;
      default: wd = in_port;
    endcase
  end

  assign rs_val = (rs == 3'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 3'd0) ? '0 : rf_q[rt];
  assign pc_we  = !stall && (PCWrite || (PCWriteCond && zero_flag));
  assign rf_we  = !stall && RegWrite && (wa != 3'd0);
  assign out_we = !stall && OutEn;

  // A/B/ALUOut, PC, register file and ports all freeze while an access is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      out_port   <= '0;
      out_strobe <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      out_strobe <= '0;
      if (!stall) begin
        a_q       <= rs_val;
        b_q       <= rt_val;
        alu_out_q <= alu_y;
      end
      if (pc_we) pc_q <= pc_next;
      if (rf_we) rf_q[wa] <= wd;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (out_we && rt == 3'(k)) begin
          out_port[k*DATA_W +: DATA_W] <= a_q;
          out_strobe[k]                <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/mips_mc_datapath.md
Name: mips_mc_datapath

Overview:
- Parametrised multi-cycle successor of the 16-bit MIPS datapath.
- One shared memory port with a req/ready handshake serves both instruction and data accesses. Instruction, data, A, B and ALU result are held in internal pipeline registers between cycles.
- Adds a hardwired-zero r0, true sign extension, a memory-stall engine and NUM_OUT independent output ports.
- Sits between the multi-cycle control FSM (drives every control input each cycle) and the memory/IO wrapper.

Parameters:
DATA_W, 16, datapath/register/address width; legal values >=16.
NUM_OUT, 2, number of output ports; legal range 1..8.
PC_STEP, 2, PC increment per instruction.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
IorD  in  1  memory address select: 0=PC, 1=ALUOut
MemStart  in  1  start a memory access; sampled only in IDLE
MemWE  in  1  access is a write; sampled with MemStart
IRWrite  in  1  load IR with returned read data; sampled with MemStart
PCWrite  in  1  unconditional PC update
PCWriteCond  in  1  PC update if zero_flag
PCSrc  in  2  next-PC select
ALUSrcA  in  1  0=PC, 1=A
ALUSrcB  in  2  ALU B operand select
ALUOp  in  3  ALU function
RegDst  in  2  write-register select
MemtoReg  in  2  write-data select
RegWrite  in  1  register-file write enable
OutEn  in  1  output-port write enable
in_port  in  DATA_W  external input
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion, one-cycle pulse
mem_req  out  1  memory request, level
mem_we  out  1  write qualifier
mem_addr  out  DATA_W  registered address
mem_wdata  out  DATA_W  registered write data (= B)
mem_busy  out  1  access outstanding
mem_done  out  1  one-cycle pulse on completion
instr  out  16  IR contents
zero_flag  out  1  combinational: ALU result == 0
out_port  out  NUM_OUT*DATA_W  packed output ports; port k occupies [k*DATA_W +: DATA_W]
out_strobe  out  NUM_OUT  one-cycle pulse per port write

Behaviour:
Reset:
- All outputs and registers clear to 0: PC, IR, MDR, A, B, ALUOut, out_port, out_strobe, mem_* and the register file.
- Memory FSM returns to IDLE.
- Reset mid-access abandons the access: mem_req=0 at the next edge, no IR/MDR load.

Memory FSM:
- IDLE, MemStart=1: latch mem_addr (PC or ALUOut), mem_wdata=B, mem_we=MemWE and the IRWrite flag; go to WAIT with mem_req=1.
- WAIT, mem_ready=1: MDR<=mem_rdata. If the latched IRWrite flag is set and the access is a read, also IR<=mem_rdata[15:0]. Then mem_req=0, mem_done=1 for one cycle, go to IDLE.
- mem_busy = (state==WAIT).
- Ignored: MemStart in WAIT; mem_ready in IDLE.
- Access latency is one request cycle plus the memory's wait cycles; a ready pulse in the first WAIT cycle completes the access at that edge.

Stall rule: while mem_busy=1, the following are blocked:
- PC, register-file, A/B/ALUOut and out_port writes;
- OutEn/RegWrite/PCWrite are ignored.
The controller must hold its state during a stall.

Decode fields:
- rs = instr[11:9], rt = instr[8:6], rd = instr[5:3], imm6 = instr[5:0].
- sext = imm6 sign-extended to DATA_W.

Registers:
- A <= R[rs], B <= R[rt] every non-stalled cycle.
- Read during a same-cycle write returns the old value; no bypass.
- r0 reads as 0; writes to r0 are discarded.

ALU operands:
- A input: ALUSrcA selects PC (0) or A (1).
- B input: ALUSrcB 00=B, 01=PC_STEP, 10=sext, 11=sext<<1.

ALUOp (result modulo 2^DATA_W):
- 000 add, 001 sub, 010 and, 011 or, 100 xor
- 101 signed slt → 1/0
- 110 sll by B[3:0], 111 srl (logical) by B[3:0]
- ALUOut <= result every non-stalled cycle.

Next PC:
- PCSrc 00 = ALU result, 01 = ALUOut, 10 = {PC[DATA_W-1:13], instr[11:0], 1'b0}, 11 = A.
- PC updates if PCWrite | (PCWriteCond & zero_flag).
- PC wraps modulo 2^DATA_W.

Register write:
- Destination: RegDst 00=rt, 01=rd, 10=r7, 11=rt.
- Data: MemtoReg 00=ALUOut, 01=MDR, 10=PC, 11=in_port.

Output ports:
- Port select sel = rt.
- OutEn with sel<NUM_OUT: port[sel]<=A and out_strobe[sel]=1 for one cycle.
- sel>=NUM_OUT: no write, no strobe.

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT → mem_req=0, PC=0, all out_port=0, mem_busy=0.
- Fetch: PC=0x0010, MemStart+IRWrite (IorD=0), mem_ready after 3 cycles → mem_req high 3 cycles, mem_addr=0x0010, IR=mem_rdata=0x2A45, mem_done pulses once. PCWrite with ALUSrcB=01 held during the stall takes effect only after done → PC=0x0012.
- Branch: imm6=0x3E (−2), A=B=5, ALUOp=001, PCWriteCond → zero_flag=1, PC=ALUOut target (PC+2−4). Repeat with A≠B → PC unchanged.
- Register file: RegWrite r0=0x1234 → reads 0. r7 via RegDst=10 with MemtoReg=11, in_port=0xBEEF → r7=0xBEEF. Same-cycle read of r7 → old value.
- Output ports, NUM_OUT=2: OutEn rt=1, A=0x00FF → out_port[31:16]=0x00FF, out_strobe=2'b10 for one cycle. rt=5 → no change.
- Width: DATA_W=32, ALUOp=110 with B=4, A=0x8000_0001 → 0x0000_0010. slt(−1,1)=1.
